valid_ready_arbiter: RTL and testbench
======================================

# valid_ready_arbiter

Round-robin arbiter that shares one downstream valid/ready data channel among NUM_REQ upstream masters. It sits in front of the channel register slices and grants the channel one packet at a time, with packets delimited by a last flag. A MAX_BURST limit forces re-arbitration so that no requester monopolises the channel. Data and handshake paths are combinational muxes once a grant is held; arbitration costs one cycle.

## Interface
- NUM_REQ, 4, number of upstream requesters (2..8)
- DATA_W, 32, data width per channel
- MAX_BURST, 16, maximum beats per grant; forced release after this many transfers
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- s_valid  input  NUM_REQ  per-requester valid
- s_ready  output  NUM_REQ  per-requester ready
- s_data  input  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
- s_last  input  NUM_REQ  per-requester last-beat-of-packet flag
- m_valid  output  1  downstream valid
- m_ready  input  1  downstream ready
- m_data  output  DATA_W  downstream data
- m_last  output  1  downstream last (forced high on the MAX_BURST-th beat)
- grant  output  NUM_REQ  registered one-hot current owner; all-zero when idle
- busy  output  1  high in state GRANT

## Operation
- Reset: state IDLE, grant 0, rr_ptr 0, beat_cnt 0. Outputs: m_valid 0, m_data 0, m_last 0, s_ready all 0, busy 0.
- FSM states:
  - IDLE: outputs are at reset values. If any s_valid is high, register the winner into grant, clear beat_cnt, and go to GRANT.
  - GRANT: connect owner g: m_valid = s_valid[g], m_data = s_data[g], m_last = s_last[g] | (beat_cnt == MAX_BURST-1), s_ready[g] = m_ready; all other s_ready bits are 0.
- Round-robin winner: the first requester with s_valid high, searching from index rr_ptr upward and wrapping modulo NUM_REQ.
- Transfer: a beat is transferred when m_valid & m_ready; beat_cnt increments on each transfer. beat_cnt width is $clog2(MAX_BURST+1).
- Release: a transfer with m_last high returns the FSM to IDLE, sets grant to 0, and sets rr_ptr = (g+1) mod NUM_REQ.
- Grant hold:
  - The grant is held while s_valid[g] is low mid-packet: m_valid follows at 0 and there is no release.
  - Other requesters' s_valid changes are ignored during GRANT.
- Forced release: on the MAX_BURST-th beat, m_last is driven high even if s_last[g] is 0. The remainder of the packet must re-arbitrate.
- Reset mid-packet: all state clears immediately (asynchronous). The partial packet is abandoned, and s_ready drops in the same instant.

## Timing
- Arbitration latency is 1 cycle. With s_valid rising before edge N while IDLE, grant and busy are high after edge N, and the first m_valid is in cycle N.
- Re-arbitration bubble is 1 cycle: after a release at edge N, the state is IDLE for cycle N, and the next owner is valid from cycle N+1.
- Throughput within a grant is 1 beat/cycle; the path from m_ready to s_ready[g] is purely combinational.
- grant, busy, rr_ptr, and beat_cnt are registered; m_valid, m_data, m_last, and s_ready are combinational from the registered grant.
- Simultaneous events:
  - Release and a new request in the same cycle: the new request is served in the next arbitration, using the updated rr_ptr.
  - A requester that has just released may win again only if no other requester is valid.

## Configuration
- ARB_FIXED_PRIO_EN:
  - Defined: the winner is the lowest-index valid requester. rr_ptr is not implemented and grant order ignores history. All other behaviour, including MAX_BURST forced release, is unchanged.
  - Undefined (default): round-robin as above.

## Test plan
- Reset: assert rst mid-simulation with s_valid=4'b1111 -> all outputs 0 and grant 0 while asserted; after release, req0 is granted 1 cycle later.
- Single packet: req2 sends 3 beats 0xA0, 0xA1, 0xA2 (last on the 3rd), with m_ready=1 -> m_data sequence A0/A1/A2 on consecutive cycles, m_last on 0xA2, grant returns to 0 in the next cycle, rr_ptr=3.
- Round-robin: all four requesters valid with 1-beat packets -> grant order 0,1,2,3,0, with 1 idle cycle between grants.
- Back-pressure: hold m_ready=0 for 5 cycles mid-packet -> m_data stable, s_ready[g]=0, no beat lost or duplicated.
- Forced release: MAX_BURST=4, req1 sends 6 beats with last only on beat 6, and req3 is also valid -> m_last on beat 4, then req3 is served, then req1 resumes with beats 5-6.
- ARB_FIXED_PRIO_EN defined, req1 and req3 continuously valid with 1-beat packets -> req1 is always granted and req3 is never granted.

Source files
------------

// File: rtl/valid_ready_arbiter.sv
// Packet-granular arbiter sharing one valid/ready channel among NUM_REQ masters.
// Define ARB_FIXED_PRIO_EN for lowest-index-wins; default is round-robin.
module valid_ready_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        s_valid,
   output logic [NUM_REQ-1:0]        s_ready,
   input  logic [NUM_REQ*DATA_W-1:0] s_data,
   input  logic [NUM_REQ-1:0]        s_last,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [DATA_W-1:0]         m_data,
   output logic                      m_last,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      busy
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t             state_reg;
   logic [NUM_REQ-1:0] grant_reg;
   logic               busy_reg;
   logic [CNT_W-1:0]   beat_cnt_reg;
   logic [NUM_REQ-1:0] winner;
   logic               found;
   logic [DATA_W-1:0]  data_masked [NUM_REQ];
   logic               xfer;

`ifdef ARB_FIXED_PRIO_EN
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && s_valid[k]) begin
            winner[k] = 1'b1;
            found     = 1'b1;
         end
      end
   end
`else
   logic [IDX_W-1:0] rr_ptr_reg;
   logic [IDX_W-1:0] next_ptr;
   logic [IDX_W:0]   idx_sum;
   logic [IDX_W-1:0] idx;

   // Search from rr_ptr upward; the extra sum bit lets non-power-of-two counts wrap.
   always_comb begin
      winner  = '0;
      found   = 1'b0;
      idx_sum = '0;
      idx     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_sum = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
         if (idx_sum >= (IDX_W+1)'(NUM_REQ))
            idx_sum = idx_sum - (IDX_W+1)'(NUM_REQ);
         idx = idx_sum[IDX_W-1:0];
         if (!found && s_valid[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   always_comb begin
      next_ptr = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_reg[k])
            next_ptr = (k == NUM_REQ - 1) ? '0 : IDX_W'(k + 1);
      end
   end
`endif

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign data_masked[gi] = grant_reg[gi] ? s_data[gi*DATA_W +: DATA_W] : '0;
   end

   always_comb begin
      m_data = '0;
      for (int k = 0; k < NUM_REQ; k++)
         m_data = m_data | data_masked[k];
   end

   // grant_reg is all-zero while idle, so these collapse to their idle values.
   assign m_valid = |(s_valid & grant_reg);
   assign m_last  = busy_reg & ((|(s_last & grant_reg)) | (beat_cnt_reg == LAST_BEAT));
   assign s_ready = grant_reg & {NUM_REQ{m_ready}};
   assign xfer    = m_valid & m_ready;
   assign grant   = grant_reg;
   assign busy    = busy_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         grant_reg    <= '0;
         busy_reg     <= 1'b0;
         beat_cnt_reg <= '0;
`ifndef ARB_FIXED_PRIO_EN
         rr_ptr_reg   <= '0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (found) begin
                  grant_reg    <= winner;
                  busy_reg     <= 1'b1;
                  beat_cnt_reg <= '0;
                  state_reg    <= GRANT;
               end
            end
            GRANT: begin
               if (xfer) begin
                  beat_cnt_reg <= beat_cnt_reg + 1'b1;
                  if (m_last) begin
                     state_reg <= IDLE;
                     grant_reg <= '0;
                     busy_reg  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
                     rr_ptr_reg <= next_ptr;
`endif
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_valid_ready_arbiter.sv
// Scoreboard bench for valid_ready_arbiter: per-requester packet sources, expected
// downstream beats queued at load time and compared as the channel transfers them.
module tb_valid_ready_arbiter;
   localparam int NR = 4;
   localparam int DW = 32;
   localparam int MB = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR-1:0]     s_valid;
   logic [NR-1:0]     s_ready;
   logic [NR*DW-1:0]  s_data;
   logic [NR-1:0]     s_last;
   logic              m_valid;
   logic              m_ready;
   logic [DW-1:0]     m_data;
   logic              m_last;
   logic [NR-1:0]     grant;
   logic              busy;

   valid_ready_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [DW-1:0] data; logic last;} beat_t;
   typedef struct packed {logic [NR-1:0] grant; logic [DW-1:0] data; logic last;} exp_t;

   beat_t src_q [NR][$];
   exp_t  exp_q [$];
   int    pass_cnt = 0;
   int    total_cnt = 0;
   logic  rel_seen = 1'b0;
   logic [NR-1:0] fire;
   exp_t  mon_e;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total_cnt++;
      if (got === want) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
   endtask

   task automatic src_push(input int r, input logic [DW-1:0] d, input logic l);
      beat_t b;
      b.data = d;
      b.last = l;
      src_q[r].push_back(b);
   endtask

   task automatic exp_push(input int r, input logic [DW-1:0] d, input logic l);
      exp_t e;
      e.grant    = '0;
      e.grant[r] = 1'b1;
      e.data     = d;
      e.last     = l;
      exp_q.push_back(e);
   endtask

   function automatic bit src_pending();
      for (int i = 0; i < NR; i++)
         if (src_q[i].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic wait_done(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || src_pending()) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   // Source driver: retire accepted beats after each edge, present the next ones.
   initial begin
      s_valid = '0;
      s_data  = '0;
      s_last  = '0;
      forever begin
         @(negedge clk);
         fire = s_valid & s_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NR; i++)
            if (fire[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
         for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() != 0) begin
               s_valid[i]         = 1'b1;
               s_data[i*DW +: DW] = src_q[i][0].data;
               s_last[i]          = src_q[i][0].last;
            end else begin
               s_valid[i]         = 1'b0;
               s_data[i*DW +: DW] = '0;
               s_last[i]          = 1'b0;
            end
         end
      end
   end

   // Downstream monitor: every transfer is compared against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            rel_seen = 1'b0;
         end else begin
            if (rel_seen) check("bubble_busy", 64'(busy), 64'd0);
            rel_seen = m_valid & m_ready & m_last;
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  check("extra_beat", 64'(m_data), 64'hFFFF_FFFF_FFFF_FFFF);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("beat_data", 64'(m_data), 64'(mon_e.data));
                  check("beat_last", 64'(m_last), 64'(mon_e.last));
                  check("beat_grant", 64'(grant), 64'(mon_e.grant));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst     = 1'b1;
      m_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_mvalid", 64'(m_valid), 64'd0);
      check("rst_mdata", 64'(m_data), 64'd0);
      check("rst_mlast", 64'(m_last), 64'd0);
      check("rst_sready", 64'(s_ready), 64'd0);
      @(posedge clk); #1;
      rst     = 1'b0;
      m_ready = 1'b1;

      // Single 3-beat packet from req2
      src_push(2, 32'hA0, 1'b0); src_push(2, 32'hA1, 1'b0); src_push(2, 32'hA2, 1'b1);
      exp_push(2, 32'hA0, 1'b0); exp_push(2, 32'hA1, 1'b0); exp_push(2, 32'hA2, 1'b1);
      wait_done("single");

      // rr_ptr now 3: req3 beats req0
      src_push(0, 32'h10, 1'b1); src_push(3, 32'h13, 1'b1);
`ifdef ARB_FIXED_PRIO_EN
      exp_push(0, 32'h10, 1'b1); exp_push(3, 32'h13, 1'b1);
`else
      exp_push(3, 32'h13, 1'b1); exp_push(0, 32'h10, 1'b1);
`endif
      wait_done("rr_ptr");

      // Reset with all requesters valid, then round-robin from 0
      @(posedge clk); #1;
      rst = 1'b1;
      src_push(0, 32'h30, 1'b1); src_push(0, 32'h34, 1'b1);
      src_push(1, 32'h31, 1'b1); src_push(2, 32'h32, 1'b1); src_push(3, 32'h33, 1'b1);
`ifdef ARB_FIXED_PRIO_EN
      exp_push(0, 32'h30, 1'b1); exp_push(0, 32'h34, 1'b1);
      exp_push(1, 32'h31, 1'b1); exp_push(2, 32'h32, 1'b1); exp_push(3, 32'h33, 1'b1);
`else
      exp_push(0, 32'h30, 1'b1); exp_push(1, 32'h31, 1'b1); exp_push(2, 32'h32, 1'b1);
      exp_push(3, 32'h33, 1'b1); exp_push(0, 32'h34, 1'b1);
`endif
      repeat (2) @(negedge clk);
      check("rst2_svalid_seen", 64'(s_valid), 64'hF);
      check("rst2_grant", 64'(grant), 64'd0);
      check("rst2_mvalid", 64'(m_valid), 64'd0);
      check("rst2_sready", 64'(s_ready), 64'd0);
      check("rst2_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_rel_idle", 64'(grant), 64'd0);
      @(negedge clk);
      check("rst_rel_grant", 64'(grant), 64'h1);
      check("rst_rel_busy", 64'(busy), 64'd1);
      wait_done("round_robin");

      // Back-pressure mid-packet on req0
      @(posedge clk); #1;
      m_ready = 1'b0;
      src_push(0, 32'hB0, 1'b0); src_push(0, 32'hB1, 1'b0);
      src_push(0, 32'hB2, 1'b0); src_push(0, 32'hB3, 1'b1);
      exp_push(0, 32'hB0, 1'b0); exp_push(0, 32'hB1, 1'b0);
      exp_push(0, 32'hB2, 1'b0); exp_push(0, 32'hB3, 1'b1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_valid && n < 20);
      check("bp_start_valid", 64'(m_valid), 64'd1);
      @(posedge clk); #1;
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("bp_data", 64'(m_data), 64'hB1);
         check("bp_sready", 64'(s_ready), 64'd0);
         check("bp_valid", 64'(m_valid), 64'd1);
      end
      @(posedge clk); #1;
      m_ready = 1'b1;
      wait_done("backpressure");

      // Forced release after MB beats; rr_ptr is 1 here
      for (int i = 0; i < 6; i++) src_push(1, 32'hC0 + 32'(i), (i == 5));
      src_push(3, 32'hD0, 1'b1);
      for (int i = 0; i < 4; i++) exp_push(1, 32'hC0 + 32'(i), (i == 3));
`ifdef ARB_FIXED_PRIO_EN
      exp_push(1, 32'hC4, 1'b0); exp_push(1, 32'hC5, 1'b1);
      exp_push(3, 32'hD0, 1'b1);
`else
      exp_push(3, 32'hD0, 1'b1);
      exp_push(1, 32'hC4, 1'b0); exp_push(1, 32'hC5, 1'b1);
`endif
      wait_done("forced");

`ifdef ARB_FIXED_PRIO_EN
      // Fixed priority: req3 starves while req1 keeps requesting
      for (int i = 0; i < 3; i++) begin
         src_push(1, 32'hE0 + 32'(i), 1'b1);
         src_push(3, 32'hF0 + 32'(i), 1'b1);
      end
      for (int i = 0; i < 3; i++) exp_push(1, 32'hE0 + 32'(i), 1'b1);
      for (int i = 0; i < 3; i++) exp_push(3, 32'hF0 + 32'(i), 1'b1);
      wait_done("fixed_prio");
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
